// File: rtl/eye_scan_estimator.sv
// Eye-scan channel estimator: sweeps sampling phases, measures the per-phase eye
// opening as min |sample| over a window, then hill-climbs one TX equaliser coefficient.
module eye_scan_estimator #(
  parameter int DATA_W     = 10,
  parameter int NUM_PHASES = 8,
  parameter int WINDOW     = 256,
  parameter int COEF_W     = 6,
  parameter int COEF_INIT  = 0,
  parameter int STEP       = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic [DATA_W-1:0]             sample,
  output logic [$clog2(NUM_PHASES)-1:0] phase_sel,
  output logic [DATA_W-2:0]             opening,
  output logic                          opening_valid,
  output logic [$clog2(NUM_PHASES)-1:0] best_phase,
  output logic [COEF_W-1:0]             coef,
  output logic                          coef_valid,
  output logic                          busy,
  output logic                          locked
);

  localparam int PH_W  = $clog2(NUM_PHASES);
  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int OP_W  = DATA_W - 1;
  localparam int SUM_W = COEF_W + 2;

  localparam logic [PH_W-1:0]         LAST_PH = PH_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]        LAST_S  = CNT_W'(WINDOW - 1);
  localparam logic signed [SUM_W-1:0] C_MAX   = SUM_W'((1 << (COEF_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] C_MIN   = SUM_W'(-(1 << (COEF_W - 1)));
  localparam logic signed [SUM_W-1:0] STEP_S  = SUM_W'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_EVAL,
    S_UPDATE,
    S_LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [OP_W-1:0]     min_q, min_d;
  logic [OP_W-1:0]     max_q, max_d;
  logic [PH_W-1:0]     idx_q, idx_d;
  logic [OP_W-1:0]     opening_q, opening_d;
  logic                open_vld_q, open_vld_d;
  logic [PH_W-1:0]     best_phase_q, best_phase_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  logic                coef_vld_q, coef_vld_d;
  logic [OP_W-1:0]     prev_q, prev_d;
  logic                dir_q, dir_d;      // 1 = step up
  logic [1:0]          rev_q, rev_d;

  logic [DATA_W-1:0]       neg;
  logic [OP_W-1:0]         mag;
  logic [OP_W-1:0]         new_min;
  logic signed [SUM_W-1:0] sum;

  // |sample|; only the most negative code overflows, and it shows up as a set MSB after negation
  always_comb begin
    neg = -sample;
    mag = sample[OP_W-1:0];
    if (sample[DATA_W-1]) mag = neg[DATA_W-1] ? '1 : neg[OP_W-1:0];
    new_min = (mag < min_q) ? mag : min_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    min_d        = min_q;
    max_d        = max_q;
    idx_d        = idx_q;
    opening_d    = opening_q;
    open_vld_d   = 1'b0;
    best_phase_d = best_phase_q;
    coef_d       = coef_q;
    coef_vld_d   = 1'b0;
    prev_d       = prev_q;
    dir_d        = dir_q;
    rev_d        = rev_q;
    sum          = '0;

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SCAN;
          cnt_d   = '0;
          phase_d = '0;
          min_d   = '1;
        end
        S_SCAN: begin
          if (sample_valid) begin
            if (cnt_q == LAST_S) begin
              cnt_d      = '0;
              min_d      = '1;
              opening_d  = new_min;
              open_vld_d = 1'b1;
              // strict compare keeps the lowest index on ties; phase 0 seeds the max
              if (phase_q == '0 || new_min > max_q) begin
                max_d = new_min;
                idx_d = phase_q;
              end
              if (phase_q == LAST_PH) begin
                phase_d = '0;
                state_d = S_EVAL;
              end else begin
                phase_d = phase_q + 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
              min_d = new_min;
            end
          end
        end
        S_EVAL: begin
          best_phase_d = idx_q;
          state_d      = S_UPDATE;
        end
        S_UPDATE: begin
          if (max_q < prev_q) begin
            dir_d = ~dir_q;
            rev_d = (rev_q == 2'd3) ? rev_q : rev_q + 1'b1;
          end else begin
            rev_d = '0;
          end
          sum = {{2{coef_q[COEF_W-1]}}, coef_q} + (dir_d ? STEP_S : -STEP_S);
          if (sum > C_MAX)      coef_d = C_MAX[COEF_W-1:0];
          else if (sum < C_MIN) coef_d = C_MIN[COEF_W-1:0];
          else                  coef_d = sum[COEF_W-1:0];
          coef_vld_d = 1'b1;
          prev_d     = max_q;
          state_d    = (rev_d >= 2'd2) ? S_LOCKED : S_SCAN;
        end
        S_LOCKED: state_d = S_LOCKED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      min_q        <= '1;
      max_q        <= '0;
      idx_q        <= '0;
      opening_q    <= '0;
      open_vld_q   <= 1'b0;
      best_phase_q <= '0;
      coef_q       <= COEF_W'(COEF_INIT);
      coef_vld_q   <= 1'b0;
      prev_q       <= '0;
      dir_q        <= 1'b1;
      rev_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      min_q        <= min_d;
      max_q        <= max_d;
      idx_q        <= idx_d;
      opening_q    <= opening_d;
      open_vld_q   <= open_vld_d;
      best_phase_q <= best_phase_d;
      coef_q       <= coef_d;
      coef_vld_q   <= coef_vld_d;
      prev_q       <= prev_d;
      dir_q        <= dir_d;
      rev_q        <= rev_d;
    end
  end

  assign phase_sel     = phase_q;
  assign opening       = opening_q;
  assign opening_valid = open_vld_q;
  assign best_phase    = best_phase_q;
  assign coef          = coef_q;
  assign coef_valid    = coef_vld_q;
  assign busy          = (state_q == S_SCAN) || (state_q == S_EVAL) || (state_q == S_UPDATE);
  assign locked        = (state_q == S_LOCKED);

endmodule
